// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with a 1-bit round-robin pointer
// and read-port hazard flags. Optional: define X0_WRITE_DROP_EN to suppress writes to x0.
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [4:0]  addrw,
    output logic        writeen,
    output logic [31:0] writeint,
    input  logic [4:0]  addr1,
    input  logic [4:0]  addr2,
    output logic        hz1,
    output logic        hz2,
    output logic        ptr
);

    // Handshake: a requester's write is taken in any cycle where its valid and
    // ready are both high; valid/addr/data must stay stable until then.

    logic        ptr_q, ptr_d;
    logic        writeen_q, writeen_d;
    logic [4:0]  addrw_q, addrw_d;
    logic [31:0] writeint_q, writeint_d;

    logic        grant0, grant1, accept, keep_write;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        sel_addr   = req0_addr;
        sel_data   = req0_data;
        ptr_d      = ptr_q;
        writeen_d  = 1'b0;
        addrw_d    = addrw_q;
        writeint_d = writeint_q;

        // A lone valid always wins; a tie goes to the requester ptr names.
        if (!reset) begin
            if (req0_valid && (!req1_valid || !ptr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end

        if (grant1) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end

        accept = grant0 | grant1;

        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end

`ifdef X0_WRITE_DROP_EN
        keep_write = accept && (sel_addr != 5'd0);
`else
        keep_write = accept;
`endif

        if (keep_write) begin
            writeen_d  = 1'b1;
            addrw_d    = sel_addr;
            writeint_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= 1'b0;
            writeen_q  <= 1'b0;
            addrw_q    <= 5'd0;
            writeint_q <= 32'd0;
        end else begin
            ptr_q      <= ptr_d;
            writeen_q  <= writeen_d;
            addrw_q    <= addrw_d;
            writeint_q <= writeint_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign addrw      = addrw_q;
    assign writeen    = writeen_q;
    assign writeint   = writeint_q;
    assign ptr        = ptr_q;

    // Hazard flags are forced low while reset is held.
    assign hz1 = !reset && writeen_q && (addrw_q == addr1);
    assign hz2 = !reset && writeen_q && (addrw_q == addr2);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench for regfile_write_arbiter: arbitration model in the
// stimulus process, write scoreboard (exp_q) checked by an independent monitor.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  addrw;
    logic        writeen;
    logic [31:0] writeint;
    logic [4:0]  addr1, addr2;
    logic        hz1, hz2;
    logic        ptr;

    regfile_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .addrw      (addrw),
        .writeen    (writeen),
        .writeint   (writeint),
        .addr1      (addr1),
        .addr2      (addr2),
        .hz1        (hz1),
        .hz2        (hz2),
        .ptr        (ptr)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard entry: {cycle tag[15:0], addr[4:0], data[31:0]}
    localparam int W = 53;
    logic [W-1:0] exp_q[$];

    // Reference state: which requester is favoured on a tie, and what was taken.
    int m_fav = 0;
    bit acc0, acc1;

    // Monitor's view of the register-file write port.
    logic [4:0]  mon_addr = '0;
    logic [31:0] mon_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit dropped(input logic [4:0] a);
`ifdef X0_WRITE_DROP_EN
        return a == 5'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Arbitration reference: who should be granted right now.
    task automatic check_cycle();
        int winner;
        winner = -1;
        if (!reset) begin
            if (req0_valid && req1_valid) winner = m_fav;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
        end
        acc0 = (winner == 0);
        acc1 = (winner == 1);
        chk("req0_ready", 32'(req0_ready), 32'(acc0));
        chk("req1_ready", 32'(req1_ready), 32'(acc1));
        chk("ptr", 32'(ptr), 32'(m_fav));
        if (acc0 && !dropped(req0_addr))
            exp_q.push_back({16'(cyc), req0_addr, req0_data});
        if (acc1 && !dropped(req1_addr))
            exp_q.push_back({16'(cyc), req1_addr, req1_data});
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        if (reset)     m_fav = 0;
        else if (acc0) m_fav = 1;
        else if (acc1) m_fav = 0;
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Monitor: every write seen must match the oldest accept, one cycle later.
    always @(negedge clk) begin
        logic exp_we;
        logic [W-1:0] e;
        while (exp_q.size() > 0 && exp_q[0][52:37] != 16'(cyc) && exp_q[0][52:37] != 16'(cyc - 1)) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write: addr %0d data %0h never written (cycle %0d)", e[36:32], e[31:0], cyc);
        end
        exp_we = (exp_q.size() > 0) && (exp_q[0][52:37] == 16'(cyc - 1));
        if (exp_we) begin
            e = exp_q.pop_front();
            mon_addr = e[36:32];
            mon_data = e[31:0];
        end
        chk("writeen", 32'(writeen), 32'(exp_we));
        chk("addrw", 32'(addrw), 32'(mon_addr));
        chk("writeint", writeint, mon_data);
        chk("hz1", 32'(hz1), 32'(!reset && exp_we && (mon_addr == addr1)));
        chk("hz2", 32'(hz2), 32'(!reset && exp_we && (mon_addr == addr2)));
    end

    always @(posedge clk) begin
        if (reset) begin
            mon_addr = '0;
            mon_data = '0;
        end
    end

    // Driver / stimulus
    initial begin
        reset = 1'b1;
        addr1 = '0;
        addr2 = '0;
        drive(0, 0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;

        // Lone requester 0 taken immediately
        drive(1, 5'd5, 32'h1234, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Both valid continuously from a fresh reset: 0,1,0,1
        reset = 1'b1; step(); reset = 1'b0;
        drive(1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
        repeat (4) step();
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Hazard on read port 1 only, then clear
        addr1 = 5'd7; addr2 = 5'd8;
        drive(1, 5'd7, 32'h77, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step(); step();

        // Reset held in the cycle req1 presents addr 9
        drive(0, 0, 0, 1, 5'd9, 32'h99);
        reset = 1'b1; step(); reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        // Reset arriving while an accepted write is in flight
        addr1 = 5'd9;
        drive(0, 0, 0, 1, 5'd9, 32'h99);
        step();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1; step(); reset = 1'b0;
        step();

        // Write to x0 from requester 1
        drive(0, 0, 0, 1, 5'd0, 32'hFF);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Write then 10 idle cycles: outputs hold
        drive(1, 5'd2, 32'h55, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (10) step();

        // Random phase: requesters hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_addr  = 5'($urandom_range(0, 7));
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_addr  = 5'($urandom_range(0, 7));
                req1_data  = $urandom;
            end
            addr1 = 5'($urandom_range(0, 7));
            addr2 = 5'($urandom_range(0, 7));
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
